adc_sampler: RTL
================

# adc_sampler

Serial-ADC front end for the loctag detector chain. Powers the LT5534 RF detector, drives the 12-bit serial ADC's chip-select and clock, and shifts in a 16-bit frame per conversion. Delivers each 12-bit sample with a one-cycle valid strobe to the loctag core's trigger and demodulation logic. Runs on the PLL-derived 50 MHz system clock.

## Interface
- `CLK_DIV`, 2: system-clock cycles per `adc_clk` half-period; ≥1.
- `FRAME_BITS`, 16: `adc_clk` cycles per conversion frame.
- `DATA_BITS`, 12: sample width, taken from the last `DATA_BITS` bits of the frame.
- `WARMUP_CYCLES`, 1000: cycles from detector enable to first conversion; ≥1.
- `QUIET_CYCLES`, 4: cycles `adc_cs` stays high between frames; ≥1.

Ports:
- `clk`  in  1: system clock; all logic on the rising edge.
- `reset`  in  1: active-low asynchronous reset.
- `enable`  in  1: request continuous sampling; level-sensitive.
- `adc_so`  in  1: ADC serial data, MSB first.
- `lt5534_en`  out  1: detector power enable.
- `adc_cs`  out  1: ADC chip-select, active low.
- `adc_clk`  out  1: ADC serial clock; idles high.
- `sample`  out  DATA_BITS: last completed sample; held until the next frame completes.
- `sample_valid`  out  1: one-cycle strobe when `sample` updates.
- `lead_err`  out  1: registered with `sample_valid`; 1 if any leading (non-data) frame bit was 1.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Reset values: `lt5534_en`=0, `adc_cs`=1, `adc_clk`=1, `sample`=0, `sample_valid`=0, `lead_err`=0, `busy`=0, state IDLE, all counters 0.
- States:
  - IDLE: outputs at idle levels. `enable`=1 → WARMUP.
  - WARMUP: `lt5534_en`=1; counts `WARMUP_CYCLES`.
    - Count done and `enable`=1 → SETUP.
    - `enable`=0 at any time → IDLE; counter cleared.
  - SETUP: `adc_cs`=0, `adc_clk`=1 for one half-period → SHIFT.
  - SHIFT: `FRAME_BITS` clock periods. Each period is a low half then a high half.
    - On the clk edge where `adc_clk` goes 0→1, `adc_so` shifts into the LSB of a `FRAME_BITS` register.
    - The bit counter increments on the same edge.
    - After the last rising edge, the high half completes → DONE.
  - DONE: one cycle.
    - `adc_cs`=1.
    - `sample` ← shift[DATA_BITS-1:0].
    - `lead_err` ← OR of shift[FRAME_BITS-1:DATA_BITS].
    - `sample_valid`=1.
    - → QUIET.
  - QUIET: `adc_cs`=1 for `QUIET_CYCLES` cycles, counted from the first QUIET cycle.
    - Then `enable`=1 → SETUP (no re-warmup).
    - Otherwise → IDLE, and `lt5534_en` drops.
- `enable` deasserted during SETUP or SHIFT has no effect. The frame completes, DONE and QUIET run, then IDLE.
- An asynchronous reset mid-frame forces all outputs to their reset values immediately. `adc_cs` rises, aborting the ADC frame, and no `sample_valid` is issued.
- A half-period tick occurs when the divider reaches `CLK_DIV`-1. The divider restarts at 0 on every entry to SETUP.
- `adc_cs`, `adc_clk` and `lt5534_en` are driven directly from registers. No combinational path from any input reaches them.

## Timing
- SETUP lasts `CLK_DIV` cycles. SHIFT lasts 2·`CLK_DIV`·`FRAME_BITS` cycles.
- With defaults, `adc_cs` is low for 2 + 64 = 66 cycles.
- `sample_valid` is asserted in the first cycle `adc_cs` is high again, i.e. cycle 66 after `adc_cs` fell.
- `sample` and `lead_err` are valid from that cycle on.
- Conversion period: `CLK_DIV`·(1+2·`FRAME_BITS`) + 1 + `QUIET_CYCLES`. Defaults: 71 cycles, 1.42 µs at 50 MHz.
- Default `adc_clk` is 12.5 MHz (80 ns period). The falling edge comes `CLK_DIV` cycles after SETUP entry.
- First `adc_cs` fall: `WARMUP_CYCLES`+1 cycles after the first cycle `enable` is seen high.
- `adc_so` is sampled unsynchronized. The ADC updates it on the `adc_clk` falling edge, a full half-period before capture.

## Test plan
- Reset then idle:
  - Stimulus: hold `reset`=0, release, `enable`=0 for 200 cycles.
  - Required: `adc_cs`=1, `adc_clk`=1, `lt5534_en`=0, `sample_valid` never pulses.
- Single conversion:
  - Stimulus: ADC model returns 0x0A5C (leading 0000, data 0xA5C).
  - Required:
    - `lt5534_en` rises the cycle after `enable`.
    - `adc_cs` falls 1001 cycles after `enable`.
    - Exactly 16 `adc_clk` low pulses, `adc_cs` low 66 cycles.
    - `sample`=0xA5C, `sample_valid` one cycle, `lead_err`=0.
- Leading-bit error:
  - Stimulus: model returns 0x8FFF.
  - Required: `sample`=0xFFF, `lead_err`=1.
- Continuous streaming:
  - Stimulus: `enable` held, model returns 0x0001, 0x0FFF, 0x0000.
  - Required: `sample_valid` pulses 71 cycles apart with those samples; `adc_cs` high exactly 5 cycles between frames.
- Enable drop:
  - Stimulus: deassert `enable` at SHIFT bit 5, then separately during WARMUP.
  - Required:
    - SHIFT case: frame completes, `sample_valid` pulses once, then IDLE with `lt5534_en`=0.
    - WARMUP case: IDLE next cycle, `adc_cs` never falls.
- Reset mid-frame:
  - Stimulus: assert `reset` at SHIFT bit 8.
  - Required: `adc_cs`=1 and `adc_clk`=1 asynchronously, no `sample_valid`, and `sample` returns to 0.

Source files
------------

// File: rtl/adc_sampler.sv
// adc_sampler: serial-ADC front end - detector power, ADC chip-select/clock, 16-bit frame capture.
// All ADC-facing outputs are registered next-state decodes, so nothing combinational reaches the pins.
module adc_sampler #(
  parameter int CLK_DIV       = 2,
  parameter int FRAME_BITS    = 16,
  parameter int DATA_BITS     = 12,
  parameter int WARMUP_CYCLES = 1000,
  parameter int QUIET_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 adc_so,
  output logic                 lt5534_en,
  output logic                 adc_cs,
  output logic                 adc_clk,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 lead_err,
  output logic                 busy
);
  localparam int CNT_MAX = WARMUP_CYCLES > QUIET_CYCLES ? WARMUP_CYCLES : QUIET_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {IDLE, WARMUP, SETUP, SHIFT, DONE, QUIET} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         div_q, div_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0]  sample_q, sample_d;
  logic                  lt_en_q, lt_en_d, cs_q, cs_d, aclk_q, aclk_d;
  logic                  valid_q, valid_d, lerr_q, lerr_d;
  logic                  tick, rise, warm_done, quiet_done;

  assign tick       = div_q == DW'(CLK_DIV - 1);
  assign rise       = state_q == SHIFT && tick && !aclk_q;
  assign warm_done  = cnt_q == CW'(WARMUP_CYCLES - 1);
  assign quiet_done = cnt_q == CW'(QUIET_CYCLES - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      sample_q <= '0;
      lt_en_q  <= 1'b0;
      cs_q     <= 1'b1;
      aclk_q   <= 1'b1;
      valid_q  <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      lt_en_q  <= lt_en_d;
      cs_q     <= cs_d;
      aclk_q   <= aclk_d;
      valid_q  <= valid_d;
      lerr_q   <= lerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = enable ? WARMUP : IDLE;
      WARMUP:  state_d = !enable ? IDLE : warm_done ? SETUP : WARMUP;
      SETUP:   state_d = tick ? SHIFT : SETUP;
      SHIFT:   state_d = tick && aclk_q && bit_q == BW'(FRAME_BITS) ? DONE : SHIFT;
      DONE:    state_d = QUIET;
      QUIET:   state_d = !quiet_done ? QUIET : enable ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In SHIFT the adc_clk register doubles as the half-period phase (0 = low half).
  always_comb begin
    cnt_d    = (state_d == state_q && (state_q == WARMUP || state_q == QUIET)) ? cnt_q + 1'b1 : '0;
    div_d    = (state_q inside {SETUP, SHIFT} && !tick) ? div_q + 1'b1 : '0;
    bit_d    = state_q == SETUP ? '0 : bit_q + BW'(rise);
    shift_d  = rise ? {shift_q[FRAME_BITS-2:0], adc_so} : shift_q;
    lt_en_d  = state_d != IDLE;
    cs_d     = !(state_d inside {SETUP, SHIFT});
    aclk_d   = state_d != SHIFT || (state_q == SHIFT && (aclk_q ^ tick));
    valid_d  = state_d == DONE;
    sample_d = valid_d ? shift_q[DATA_BITS-1:0] : sample_q;
    lerr_d   = valid_d ? |shift_q[FRAME_BITS-1:DATA_BITS] : lerr_q;
  end

  assign lt5534_en    = lt_en_q;
  assign adc_cs       = cs_q;
  assign adc_clk      = aclk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign lead_err     = lerr_q;
  assign busy         = state_q != IDLE;
endmodule
